// File: rtl/bproc_pkg.sv
// Shared types and helpers for the branch-redirect path: FSM states, widths and
// the instruction-buffer age function.
package bproc_pkg;

    localparam int unsigned PC_W  = 32;
    localparam int unsigned POS_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        REDIRECT,
        FLUSH
    } state_e;

    // Distance from the buffer head; wraps naturally so smaller is always older.
    function automatic logic [POS_W-1:0] age(input logic [POS_W-1:0] pos,
                                             input logic [POS_W-1:0] head);
        return pos - head;
    endfunction

endpackage

// File: rtl/bredirect_ctrl_if.sv
// Mispredict-report and fetch-redirect signal bundle for bredirect_ctrl.
interface bredirect_ctrl_if;
    import bproc_pkg::*;

    logic [1:0]       i_req;
    logic [PC_W-1:0]  i_pc0;
    logic [PC_W-1:0]  i_pc1;
    logic [POS_W-1:0] i_pos0;
    logic [POS_W-1:0] i_pos1;
    logic [POS_W-1:0] i_head;
    logic             i_hit;
    logic             i_fetch_ready;
    logic             o_redirect_valid;
    logic [PC_W-1:0]  o_redirect_pc;
    logic [POS_W-1:0] o_errPos;
    logic             o_flush;
    logic             o_busy;
    logic [2:0]       o_counter;
    logic             o_throttle;

    modport master (
        output i_req, i_pc0, i_pc1, i_pos0, i_pos1, i_head, i_hit, i_fetch_ready,
        input  o_redirect_valid, o_redirect_pc, o_errPos, o_flush, o_busy, o_counter,
               o_throttle
    );

    modport slave (
        input  i_req, i_pc0, i_pc1, i_pos0, i_pos1, i_head, i_hit, i_fetch_ready,
        output o_redirect_valid, o_redirect_pc, o_errPos, o_flush, o_busy, o_counter,
               o_throttle
    );

endinterface

// File: rtl/bage_sel.sv
// Combinational two-input oldest-picker. Ties go to input 0, so sel=1 means input 1
// is strictly older than input 0.
module bage_sel
    import bproc_pkg::*;
(
    input  logic [POS_W-1:0] pos0,
    input  logic [POS_W-1:0] pos1,
    input  logic [POS_W-1:0] head,
    input  logic [1:0]       req,
    output logic             sel,
    output logic             valid,
    output logic [POS_W-1:0] age_o
);

    logic [POS_W-1:0] age0;
    logic [POS_W-1:0] age1;

    always_comb begin
        age0  = age(pos0, head);
        age1  = age(pos1, head);
        valid = |req;
        if (req == 2'b11) begin
            sel = (age1 < age0);
        end else begin
            sel = req[1];
        end
        age_o = sel ? age1 : age0;
    end

endmodule

// File: rtl/bredirect_ctrl.sv
// Branch-redirect controller: picks the oldest mispredict, hands it to fetch over
// valid/ready, then holds a fixed flush window. Tracks consecutive mispredicts.
module bredirect_ctrl
    import bproc_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned THROTTLE_TH  = 4
) (
    input  logic             fire,
    input  logic             rst,
    bredirect_ctrl_if.slave  bus
);

    state_e           state_q;
    logic [PC_W-1:0]  pend_pc_q;
    logic [POS_W-1:0] pend_pos_q;
    logic [3:0]       flush_cnt_q;
    logic [2:0]       counter_q;
    logic [2:0]       counter_d;
    logic             valid_q;
    logic             flush_q;
    logic             busy_q;
    logic             throttle_q;

    logic             pick_sel;
    logic             pick_valid;
    logic [POS_W-1:0] pick_age;
    logic             cmp_sel;
    logic             cmp_valid;
    logic [POS_W-1:0] cmp_age;
    logic [PC_W-1:0]  cand_pc;
    logic [POS_W-1:0] cand_pos;
    logic             handshake;
    logic             unused_sig;

    bage_sel u_pick (
        .pos0  (bus.i_pos0),
        .pos1  (bus.i_pos1),
        .head  (bus.i_head),
        .req   (bus.i_req),
        .sel   (pick_sel),
        .valid (pick_valid),
        .age_o (pick_age)
    );

    // Pending entry sits on input 0 so an equal-age candidate never replaces it.
    bage_sel u_cmp (
        .pos0  (pend_pos_q),
        .pos1  (cand_pos),
        .head  (bus.i_head),
        .req   ({pick_valid, 1'b1}),
        .sel   (cmp_sel),
        .valid (cmp_valid),
        .age_o (cmp_age)
    );

    assign unused_sig = ^{pick_age, cmp_valid, cmp_age};

    always_comb begin
        cand_pc   = pick_sel ? bus.i_pc1  : bus.i_pc0;
        cand_pos  = pick_sel ? bus.i_pos1 : bus.i_pos0;
        handshake = (state_q == REDIRECT) && bus.i_fetch_ready;
        counter_d = counter_q;
        if (handshake) begin
            counter_d = (counter_q == 3'd7) ? 3'd7 : counter_q + 3'd1;
        end else if (bus.i_hit) begin
            counter_d = 3'd0;
        end
    end

    always_ff @(posedge fire or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pend_pc_q   <= '0;
            pend_pos_q  <= '0;
            flush_cnt_q <= '0;
            counter_q   <= '0;
            valid_q     <= 1'b0;
            flush_q     <= 1'b0;
            busy_q      <= 1'b0;
            throttle_q  <= 1'b0;
        end else begin
            counter_q  <= counter_d;
            throttle_q <= (counter_d >= 3'(THROTTLE_TH));
            unique case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        pend_pc_q  <= cand_pc;
                        pend_pos_q <= cand_pos;
                        state_q    <= REDIRECT;
                        valid_q    <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                REDIRECT: begin
                    if (handshake) begin
                        state_q     <= FLUSH;
                        flush_cnt_q <= 4'(FLUSH_CYCLES - 1);
                        valid_q     <= 1'b0;
                        flush_q     <= 1'b1;
                    end else if (cmp_sel) begin
                        pend_pc_q  <= cand_pc;
                        pend_pos_q <= cand_pos;
                    end
                end
                FLUSH: begin
                    if (flush_cnt_q == 4'd0) begin
                        state_q <= IDLE;
                        flush_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        flush_cnt_q <= flush_cnt_q - 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_redirect_valid = valid_q;
    assign bus.o_redirect_pc    = pend_pc_q;
    assign bus.o_errPos         = pend_pos_q;
    assign bus.o_flush          = flush_q;
    assign bus.o_busy           = busy_q;
    assign bus.o_counter        = counter_q;
    assign bus.o_throttle       = throttle_q;

endmodule
